// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32 decode stage: opcodes, ALU control codes and the
// decoded-instruction record carried through the output buffer.
package decode_stage_pkg;

  typedef enum logic [6:0] {
    RType      = 7'b0110011,
    ITypeLogic = 7'b0010011,
    ITypeLoad  = 7'b0000011,
    ITypeJalr  = 7'b1100111,
    SType      = 7'b0100011,
    BType      = 7'b1100011,
    JType      = 7'b1101111,
    UTypeAuipc = 7'b0010111,
    UTypeLui   = 7'b0110111
  } opcode_t;

  typedef logic [31:0] imm_t;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9
  } alu_op_t;

  localparam logic [6:0] Funct7Base   = 7'b0000000;
  localparam logic [6:0] Funct7Alt    = 7'b0100000;
  localparam logic [6:0] Funct7MulDiv = 7'b0000001;

  typedef struct packed {
    logic [31:0] pc;
    opcode_t     opcode;
    alu_op_t     alu_control;
    imm_t        imm_ext;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        reg_write;
    logic        is_muldiv;
    logic        illegal;
  } decoded_instr_t;

  // R/I/U/J formats produce a register result; S/B never do.
  function automatic logic opcode_writes_rd(input logic [6:0] op);
    case (op)
      RType, ITypeLogic, ITypeLoad, ITypeJalr, JType, UTypeAuipc, UTypeLui: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ALUdecoder.sv
// Maps opcode/funct3/funct7 to the 4-bit ALU control code. funct7 is only
// consulted for the add/sub and shift-right distinctions.
module ALUdecoder
  import decode_stage_pkg::*;
(
  input  opcode_t    opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    alu_control
);

  always_comb begin
    alu_control = AluAdd;
    case (opcode)
      RType, ITypeLogic: begin
        case (funct3)
          // Immediate add has no subtract form; imm bits in funct7 are ignored.
          3'b000:  alu_control = (opcode == RType && funct7[5]) ? AluSub : AluAdd;
          3'b001:  alu_control = AluSll;
          3'b010:  alu_control = AluSlt;
          3'b011:  alu_control = AluSltu;
          3'b100:  alu_control = AluXor;
          3'b101:  alu_control = funct7[5] ? AluSra : AluSrl;
          3'b110:  alu_control = AluOr;
          default: alu_control = AluAnd;
        endcase
      end
      BType:   alu_control = AluSub;
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/decode_stage_core.sv
// Purely combinational RV32 decoder: instruction word and PC in, one
// decoded_instr_t out, with illegal encodings squashed to a harmless record.
module decode_core
  import decode_stage_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]    instr,
  input  logic [31:0]    pc,
  output decoded_instr_t decoded
);

  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
  imm_t       imm;
  logic       illegal, is_muldiv;
  logic [6:0] alu_funct7;
  alu_op_t    alu_control;

  assign op     = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    rd         = 5'd0;
    rs1        = 5'd0;
    rs2        = 5'd0;
    imm        = '0;
    illegal    = 1'b0;
    is_muldiv  = 1'b0;
    alu_funct7 = 7'd0;
    case (op)
      RType: begin
        rd         = instr[11:7];
        rs1        = instr[19:15];
        rs2        = instr[24:20];
        alu_funct7 = funct7;
        if (funct7 == Funct7MulDiv) begin
          if (ENABLE_M) is_muldiv = 1'b1;
          else          illegal   = 1'b1;
          alu_funct7 = 7'd0;
        end else if (funct7 == Funct7Alt) begin
          if (funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
        end else if (funct7 != Funct7Base) begin
          illegal = 1'b1;
        end
      end
      ITypeLogic, ITypeLoad, ITypeJalr: begin
        rd  = instr[11:7];
        rs1 = instr[19:15];
        imm = {{20{instr[31]}}, instr[31:20]};
        if (op == ITypeLogic) alu_funct7 = funct7;
        if (op == ITypeJalr && funct3 != 3'b000) illegal = 1'b1;
      end
      SType: begin
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      BType: begin
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      JType: begin
        rd  = instr[11:7];
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      UTypeAuipc, UTypeLui: begin
        rd  = instr[11:7];
        imm = {instr[31:12], 12'd0};
      end
      default: illegal = 1'b1;
    endcase
    // Squash everything except pc/opcode/funct3 so a trap sees a clean record.
    if (illegal) begin
      rd         = 5'd0;
      rs1        = 5'd0;
      rs2        = 5'd0;
      imm        = '0;
      is_muldiv  = 1'b0;
      alu_funct7 = 7'd0;
    end
  end

  ALUdecoder u_alu_decoder (
    .opcode      (opcode_t'(op)),
    .funct3      (funct3),
    .funct7      (alu_funct7),
    .alu_control (alu_control)
  );

  always_comb begin
    decoded             = '0;
    decoded.pc          = pc;
    decoded.opcode      = opcode_t'(op);
    decoded.alu_control = alu_control;
    decoded.imm_ext     = imm;
    decoded.funct3      = funct3;
    decoded.rd          = rd;
    decoded.rs1         = rs1;
    decoded.rs2         = rs2;
    decoded.reg_write   = !illegal && opcode_writes_rd(op) && (rd != 5'd0);
    decoded.is_muldiv   = is_muldiv;
    decoded.illegal     = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode feeding a DEPTH-entry output FIFO with
// valid/ready on both sides; in_ready depends on registered occupancy only.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output opcode_t     out_opcode,
  output logic [3:0]  out_alu_control,
  output imm_t        out_imm_ext,
  output logic [2:0]  out_funct3,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_reg_write,
  output logic        out_is_muldiv,
  output logic        out_illegal
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  decoded_instr_t decoded;
  decoded_instr_t head;
  decoded_instr_t mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;

  decode_core #(
    .ENABLE_M (ENABLE_M)
  ) u_decode_core (
    .instr   (in_instr),
    .pc      (in_pc),
    .decoded (decoded)
  );

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= decoded;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Stale entries left behind by a flush or pop are never exposed.
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc          = head.pc;
  assign out_opcode      = head.opcode;
  assign out_alu_control = head.alu_control;
  assign out_imm_ext     = head.imm_ext;
  assign out_funct3      = head.funct3;
  assign out_rd          = head.rd;
  assign out_rs1         = head.rs1;
  assign out_rs2         = head.rs2;
  assign out_reg_write   = head.reg_write;
  assign out_is_muldiv   = head.is_muldiv;
  assign out_illegal     = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances (M enabled / disabled) share
// one stimulus stream; expected values are hand-decoded instruction fields.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_reg_write, out_is_muldiv, out_illegal;
  logic [31:0] out_pc;
  opcode_t     out_opcode;
  logic [3:0]  out_alu_control;
  imm_t        out_imm_ext;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  logic        b_in_ready, b_out_valid, b_reg_write, b_is_muldiv, b_illegal;
  logic [31:0] b_pc;
  opcode_t     b_opcode;
  logic [3:0]  b_alu_control;
  imm_t        b_imm_ext;
  logic [2:0]  b_funct3;
  logic [4:0]  b_rd, b_rs1, b_rs2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(2), .ENABLE_M(1'b1)) u_dut (
    .clk (clk), .reset_n (reset_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready), .in_instr (in_instr), .in_pc (in_pc),
    .out_valid (out_valid), .out_ready (out_ready), .out_pc (out_pc),
    .out_opcode (out_opcode), .out_alu_control (out_alu_control),
    .out_imm_ext (out_imm_ext), .out_funct3 (out_funct3), .out_rd (out_rd),
    .out_rs1 (out_rs1), .out_rs2 (out_rs2), .out_reg_write (out_reg_write),
    .out_is_muldiv (out_is_muldiv), .out_illegal (out_illegal)
  );

  decode_stage #(.DEPTH(2), .ENABLE_M(1'b0)) u_dut_nom (
    .clk (clk), .reset_n (reset_n), .flush (flush),
    .in_valid (in_valid), .in_ready (b_in_ready), .in_instr (in_instr), .in_pc (in_pc),
    .out_valid (b_out_valid), .out_ready (out_ready), .out_pc (b_pc),
    .out_opcode (b_opcode), .out_alu_control (b_alu_control),
    .out_imm_ext (b_imm_ext), .out_funct3 (b_funct3), .out_rd (b_rd),
    .out_rs1 (b_rs1), .out_rs2 (b_rs2), .out_reg_write (b_reg_write),
    .out_is_muldiv (b_is_muldiv), .out_illegal (b_illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    check_eq("send_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_head();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic rw, input logic ill);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".pc"}, out_pc, pc);
    check_eq({tag, ".rd"}, 32'(out_rd), 32'(rd));
    check_eq({tag, ".rs1"}, 32'(out_rs1), 32'(rs1));
    check_eq({tag, ".rs2"}, 32'(out_rs2), 32'(rs2));
    check_eq({tag, ".imm"}, out_imm_ext, imm);
    check_eq({tag, ".reg_write"}, 32'(out_reg_write), 32'(rw));
    check_eq({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_out_imm", out_imm_ext, 32'd0);
    reset_n = 1'b1;
    tick();

    // addi x1,x0,5
    send(32'h00500093, 32'h100);
    check_head("addi", 32'h100, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0);
    check_eq("addi.alu", 32'(out_alu_control), 32'(AluAdd));
    check_eq("addi.opcode", 32'(out_opcode), 32'h13);
    pop_head();
    check_eq("addi.drained", 32'(out_valid), 32'd0);

    // lw x2,-4(x1)
    send(32'hFFC0A103, 32'h104);
    check_head("lw", 32'h104, 5'd2, 5'd1, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b0);
    check_eq("lw.funct3", 32'(out_funct3), 32'd2);
    pop_head();

    // mul x3,x1,x2 : legal with M, illegal without
    send(32'h022081B3, 32'h108);
    check_head("mul", 32'h108, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0);
    check_eq("mul.is_muldiv", 32'(out_is_muldiv), 32'd1);
    check_eq("mul.alu_idle", 32'(out_alu_control), 32'(AluAdd));
    check_eq("mul_nom.illegal", 32'(b_illegal), 32'd1);
    check_eq("mul_nom.reg_write", 32'(b_reg_write), 32'd0);
    check_eq("mul_nom.is_muldiv", 32'(b_is_muldiv), 32'd0);
    check_eq("mul_nom.rd", 32'(b_rd), 32'd0);
    check_eq("mul_nom.pc", b_pc, 32'h108);
    pop_head();

    // sub x3,x1,x2
    send(32'h402081B3, 32'h10C);
    check_head("sub", 32'h10C, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0);
    check_eq("sub.alu", 32'(out_alu_control), 32'(AluSub));
    check_eq("sub_nom.illegal", 32'(b_illegal), 32'd0);
    pop_head();

    // sw x2,4(x1): no rd write
    send(32'h0020A223, 32'h110);
    check_head("sw", 32'h110, 5'd0, 5'd1, 5'd2, 32'd4, 1'b0, 1'b0);
    pop_head();

    // nop (addi x0,x0,0): rd=0 means no write
    send(32'h00000013, 32'h114);
    check_head("nop", 32'h114, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    pop_head();

    // lui x5,0x12345
    send(32'h123452B7, 32'h118);
    check_head("lui", 32'h118, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b0);
    pop_head();

    // unknown opcode, and jalr with funct3=001
    send(32'hFFFFFFFF, 32'h11C);
    check_head("badop", 32'h11C, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
    pop_head();
    send(32'h000090E7, 32'h120);
    check_head("jalr_f3", 32'h120, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
    pop_head();

    // Backpressure: three offered, two accepted, drained in order
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
    tick();
    check_eq("bp.ready_after1", 32'(in_ready), 32'd1);
    in_pc = 32'h204;
    tick();
    check_eq("bp.ready_full", 32'(in_ready), 32'd0);
    check_eq("bp.head0", out_pc, 32'h200);
    in_pc = 32'h208;
    tick();
    check_eq("bp.still_full", 32'(in_ready), 32'd0);
    check_eq("bp.head_stable", out_pc, 32'h200);
    out_ready = 1'b1;
    tick();
    check_eq("bp.head1", out_pc, 32'h204);
    check_eq("bp.ready_again", 32'(in_ready), 32'd1);
    tick();
    check_eq("bp.head2", out_pc, 32'h208);
    in_valid = 1'b0;
    tick();
    check_eq("bp.empty", 32'(out_valid), 32'd0);

    // Full throughput with out_ready held high
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h300 + 32'(4 * i);
      tick();
      check_eq("tp.in_ready", 32'(in_ready), 32'd1);
      check_eq("tp.pc", out_pc, 32'h300 + 32'(4 * i));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check_eq("tp.empty", 32'(out_valid), 32'd0);

    // Flush with buffer full and a push offered in the same cycle
    send(32'h00100093, 32'h400);
    send(32'h00100093, 32'h404);
    in_valid = 1'b1; in_pc = 32'h408; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush.out_valid", 32'(out_valid), 32'd0);
    check_eq("flush.in_ready", 32'(in_ready), 32'd1);
    tick();
    check_eq("flush.dropped", 32'(out_valid), 32'd0);
    send(32'h00100093, 32'h40C);
    check_eq("flush.next_pc", out_pc, 32'h40C);
    pop_head();

    // Asynchronous reset mid-cycle with an entry buffered
    send(32'h00100093, 32'h500);
    #3 reset_n = 1'b0;
    #1;
    check_eq("arst.out_valid", 32'(out_valid), 32'd0);
    check_eq("arst.in_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("arst.still_empty", 32'(out_valid), 32'd0);
    send(32'h00500093, 32'h504);
    check_head("arst.first", 32'h504, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction decode stage for the RV32 core, sitting between the fetch stage and the register-read/execute stage. Each accepted instruction word and PC is decoded combinationally, then queued in a small output buffer of `DEPTH` entries with valid/ready handshakes on both sides. Beyond plain field extraction, the stage adds:

- illegal-instruction detection,
- optional M-extension decode,
- a register-write flag,
- a pipeline flush.

## Interface
Parameters:
- `DEPTH`, 2, output buffer entries (1 or 2); 2 gives full throughput.
- `ENABLE_M`, 0, when 1, R-type with funct7=0000001 decodes as mul/div; when 0 it is illegal.

Ports:
- `clk`  in  1  clock. All state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all buffered entries.
- `in_valid`  in  1  fetch presents `in_instr`/`in_pc`.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of `in_instr`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes head entry.
- `out_pc`  out  32  PC of the head entry.
- `out_opcode`  out  `opcode_t`  instr[6:0].
- `out_alu_control`  out  4  ALU control code from `ALUdecoder`.
- `out_imm_ext`  out  `imm_t`  sign/format-extended immediate.
- `out_funct3`  out  3  funct3 field.
- `out_rd`  out  5  destination register.
- `out_rs1`  out  5  first source register.
- `out_rs2`  out  5  second source register.
- `out_reg_write`  out  1  instruction writes `rd` and `rd`≠0.
- `out_is_muldiv`  out  1  M-extension op; funct3 selects the operation.
- `out_illegal`  out  1  unsupported encoding.

## Operation
**Decode (combinational, before the buffer)**
- Field rules per opcode:
  - R-type: rd, rs1, rs2 taken from the instruction.
  - I-type (logic, load, jalr): rd and rs1; rs2=0.
  - S/B-type: rs1 and rs2; rd=0.
  - U/J-type: rd only.
  - All unused fields are forced to 0.
- Immediate: I/S/B/J/U formats per the RV32I spec; R-type and illegal instructions give 0. No latches anywhere.
- funct7 passed to `ALUdecoder`:
  - instr[31:25] for R-type and I-type logic;
  - 0 otherwise;
  - 0 when `out_is_muldiv`=1, so the ALU path idles.
- `out_reg_write`: 1 for R, I, U and J types with rd≠0; 0 for S, B and illegal.
- `out_illegal` is set when any of these holds:
  - opcode is outside {RType, IType_logic, IType_load, IType_jalr, SType, BType, JType, UType_auipc, UType_lui};
  - R-type with funct7 ∉ {0000000, 0100000}, plus 0000001 when `ENABLE_M`;
  - funct7=0100000 with funct3 ∉ {000, 101};
  - IType_jalr with funct3≠000.
- For an illegal instruction, all register fields, `out_reg_write` and `out_is_muldiv` are 0; `out_pc` is kept for the trap.

**Buffer**
- FIFO of `DEPTH` decoded entries, tracked by an occupancy count.
- Push when `in_valid & in_ready`.
- Pop when `out_valid & out_ready`.
- `in_ready` = count<`DEPTH`, from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- Simultaneous push and pop at count=1 leaves the count unchanged; the new entry goes behind the head.
- At count=`DEPTH`, `in_ready`=0, so no push can occur.
- `flush`:
  - count becomes 0 next cycle and `in_ready` is 1;
  - a push in the same cycle as `flush` is dropped;
  - `flush` has priority over push and pop.

## Timing
- Reset (async assert, sync release):
  - count=0, so `out_valid`=0 and `in_ready`=1;
  - all `out_*` data outputs are 0.
- Latency: an instruction accepted in cycle N is visible on `out_*` with `out_valid`=1 in cycle N+1.
- Throughput:
  - `DEPTH`=2: 1 instruction per cycle with `out_ready` held high.
  - `DEPTH`=1: 1 instruction per 2 cycles.
- Head outputs hold stable while `out_valid & !out_ready`.
- Reset asserted mid-stream discards all entries immediately, with no handshake.

## Structure
- Shared package (`types.svh`): new `decoded_instr_t` struct carrying pc, opcode, alu_control, imm_ext, funct3, rd, rs1, rs2, reg_write, is_muldiv, illegal. Existing `opcode_t`, `imm_t` and `alu_op_t` are reused.
- Sub-module `decode_core`: purely combinational, instr/pc → `decoded_instr_t`; it instantiates `ALUdecoder`.
- `decode_stage` holds only the buffer and control logic.

## Test plan
- Reset, then `in_instr`=0x00500093 (addi x1,x0,5) → next cycle `out_valid`=1, rd=1, rs1=0, rs2=0, imm=5, reg_write=1, ALU add code.
- 0xFFC0A103 (lw x2,-4(x1)) → imm=0xFFFFFFFC, rd=2, rs1=1, funct3=010, reg_write=1.
- 0x022081B3 (mul x3,x1,x2): with `ENABLE_M`=1 → is_muldiv=1, illegal=0; with `ENABLE_M`=0 → illegal=1, reg_write=0. 0x402081B3 (sub) → ALU sub code, illegal=0.
- `out_ready`=0 while streaming three instructions → `in_ready` falls after `DEPTH` accepts, head stays stable; releasing `out_ready` drains them in order with no loss or duplication.
- `flush` with the buffer full and `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1; the flushed-cycle instruction never appears.
- `reset_n` low mid-stream → `out_valid` drops asynchronously; after release, count=0 and the first new instruction appears 1 cycle after acceptance.
